kbd_irq_ctrl: RTL and testbench

//  Keyboard interrupt source sitting directly upstream of the riscv64 core's interrupt path.

---
 rtl/kbd_pkg.sv | 14 +
 rtl/kbd_irq_ctrl_fifo.sv | 54 +++++
 rtl/kbd_irq_ctrl.sv | 109 ++++++++++
 tb/tb_kbd_irq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared addresses, vector codes and FSM state type for the keyboard interrupt source
package kbd_pkg;
   localparam logic [63:0] KEY_BASE = 64'h0000_0000_8000_0010;
   localparam logic [63:0] STAT_OFF = 64'd8;
   localparam logic [63:0] CTRL_OFF = 64'd16;
   localparam logic [3:0]  IRQ_KEY  = 4'd1;
   localparam logic [3:0]  IRQ_NONE = 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      GAP
   } kbd_state_t;
endpackage

// File: rtl/kbd_irq_ctrl_fifo.sv
// rtl/kbd_irq_ctrl_fifo.sv - scancode FIFO with combinational head; a pop frees room for a same-edge push
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/kbd_irq_ctrl.sv
// rtl/kbd_irq_ctrl.sv - keyboard interrupt source: scancode FIFO, request FSM and bus register file
module kbd_irq_ctrl
   import kbd_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [7:0]  key_data,
   input  logic [63:0] bus_address,
   input  logic        bus_read_enable,
   output logic [63:0] bus_read_data,
   input  logic        bus_write_enable,
   input  logic [63:0] bus_write_data,
   output logic [3:0]  interrupt_vector,
   input  logic        interrupt_done
);
   localparam int CW = $clog2(DEPTH) + 1;

   kbd_state_t      state;
   kbd_state_t      state_next;
   logic            irq_en;
   logic            ovf;
   logic [7:0]      head;
   logic [CW-1:0]   count;
   logic            full;
   logic            empty;
   logic            pop;
   logic            ovf_set;
   logic            sel_data;
   logic            sel_stat;
   logic            sel_ctrl;
   logic            unused_ok;

   assign sel_data = (bus_address == KEY_BASE);
   assign sel_stat = (bus_address == KEY_BASE + STAT_OFF);
   assign sel_ctrl = (bus_address == KEY_BASE + CTRL_OFF);

   // Only an acknowledged pending request consumes the head byte.
   assign pop     = (state == PEND) && interrupt_done && !empty;
   assign ovf_set = key_valid && full && !pop;

   assign unused_ok = &{1'b0, bus_read_enable, bus_write_data[63:9], bus_write_data[7:1]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (key_valid),
      .pop   (pop),
      .wdata (key_data),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_en <= 1'b1;
         ovf    <= 1'b0;
      end else begin
         if (bus_write_enable && sel_ctrl)
            irq_en <= bus_write_data[0];
         if (ovf_set)
            ovf <= 1'b1;
         else if (bus_write_enable && sel_stat && bus_write_data[8])
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (count != '0 && irq_en) state_next = PEND;
         PEND:    if (interrupt_done)        state_next = GAP;
                  else if (!irq_en)          state_next = IDLE;
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // GAP keeps the vector low so the core never sees the head before the pop lands.
   always_comb begin
      interrupt_vector = IRQ_NONE;
      if (state == PEND)
         interrupt_vector = IRQ_KEY;
   end

   always_comb begin
      bus_read_data = '0;
      if (sel_data)
         bus_read_data = {56'b0, head};
      else if (sel_stat)
         bus_read_data = {54'b0, irq_en, ovf, 8'(count)};
      else if (sel_ctrl)
         bus_read_data = {63'b0, irq_en};
   end
endmodule

// File: tb/tb_kbd_irq_ctrl.sv
// tb/tb_kbd_irq_ctrl.sv - scoreboard bench with queue reference model for kbd_irq_ctrl
module tb_kbd_irq_ctrl;
   import kbd_pkg::*;

   localparam int DEPTH = 8;
   localparam logic [63:0] STAT = KEY_BASE + STAT_OFF;
   localparam logic [63:0] CTRL = KEY_BASE + CTRL_OFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        key_valid;
   logic [7:0]  key_data;
   logic [63:0] bus_address;
   logic        bus_read_enable;
   logic [63:0] bus_read_data;
   logic        bus_write_enable;
   logic [63:0] bus_write_data;
   logic [3:0]  interrupt_vector;
   logic        interrupt_done;

   logic [63:0] drv_addr;
   logic [63:0] mon_addr = '0;
   logic        main_rd;
   logic        ack_ok;
   int          ack_pct;

   int pass_cnt = 0;
   int total    = 0;

   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   logic       m_irq_en = 1'b1;
   logic       m_ovf    = 1'b0;

   always #5 clk = ~clk;

   assign bus_address     = (bus_write_enable || main_rd) ? drv_addr : mon_addr;
   assign bus_read_enable = 1'b1;

   kbd_irq_ctrl #(.DEPTH(DEPTH)) dut (
      .clk              (clk),
      .reset            (reset),
      .key_valid        (key_valid),
      .key_data         (key_data),
      .bus_address      (bus_address),
      .bus_read_enable  (bus_read_enable),
      .bus_read_data    (bus_read_data),
      .bus_write_enable (bus_write_enable),
      .bus_write_data   (bus_write_data),
      .interrupt_vector (interrupt_vector),
      .interrupt_done   (interrupt_done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: a byte queue plus two flags, updated with the rules of each clock edge.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         exp_q.delete();
         m_irq_en = 1'b1;
         m_ovf    = 1'b0;
      end else begin
         if (interrupt_done && mq.size() != 0)
            void'(mq.pop_front());
         if (bus_write_enable && bus_address == STAT && bus_write_data[8])
            m_ovf = 1'b0;
         if (bus_write_enable && bus_address == CTRL)
            m_irq_en = bus_write_data[0];
         if (key_valid) begin
            if (mq.size() < DEPTH) begin
               mq.push_back(key_data);
               exp_q.push_back(key_data);
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
   end

   // Monitor: acks requests, checks served bytes, gap cycles, latency and status.
   int pend_cnt = 0;
   bit gap_chk  = 1'b0;
   always @(negedge clk) begin
      #2;
      interrupt_done = 1'b0;
      if (!reset) begin
         pend_cnt = 0;
         gap_chk  = 1'b0;
      end else begin
         if (gap_chk) begin
            check("gap_vector", {60'b0, interrupt_vector}, {60'b0, IRQ_NONE});
            gap_chk = 1'b0;
         end else if (interrupt_vector == IRQ_KEY) begin
            pend_cnt = 0;
            if (ack_ok && !bus_write_enable && !main_rd && $urandom_range(0, 99) < ack_pct) begin
               mon_addr = KEY_BASE;
               #1;
               if (exp_q.size() == 0)
                  check("irq_without_data", {60'b0, interrupt_vector}, {60'b0, IRQ_NONE});
               else
                  check("head_byte", bus_read_data, {56'b0, exp_q.pop_front()});
               interrupt_done = 1'b1;
               gap_chk        = 1'b1;
            end
         end else if (mq.size() != 0 && m_irq_en) begin
            pend_cnt++;
            if (pend_cnt >= 2) begin
               check("irq_latency", {60'b0, interrupt_vector}, {60'b0, IRQ_KEY});
               pend_cnt = 0;
            end
         end else begin
            pend_cnt = 0;
         end
         if (!interrupt_done && !bus_write_enable && !main_rd) begin
            mon_addr = STAT;
            #1;
            check("status", bus_read_data, {54'b0, m_irq_en, m_ovf, 8'(mq.size())});
         end
      end
   end

   task automatic push(input logic [7:0] b);
      key_valid = 1'b1;
      key_data  = b;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic wr(input logic [63:0] addr, input logic [63:0] data);
      bus_write_enable = 1'b1;
      drv_addr         = addr;
      bus_write_data   = data;
      @(negedge clk);
      bus_write_enable = 1'b0;
   endtask

   task automatic rd(input logic [63:0] addr, input string name, input logic [63:0] exp);
      main_rd  = 1'b1;
      drv_addr = addr;
      #1;
      check(name, bus_read_data, exp);
      #3;
      main_rd = 1'b0;
   endtask

   initial begin
      reset = 1'b0; key_valid = 1'b0; key_data = '0; bus_write_enable = 1'b0;
      bus_write_data = '0; drv_addr = '0; main_rd = 1'b0; ack_ok = 1'b0; ack_pct = 100;
      interrupt_done = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_vector", {60'b0, interrupt_vector}, {60'b0, IRQ_NONE});
      rd(STAT, "reset_status", 64'h200);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      rd(KEY_BASE, "reset_data", 64'h0);
      @(negedge clk);

      // single byte: request one edge after the push edge, then a gap
      push(8'h1C);
      check("t1_vec_after_push", {60'b0, interrupt_vector}, {60'b0, IRQ_NONE});
      ack_ok = 1'b1;
      @(negedge clk);
      check("t1_vec_next", {60'b0, interrupt_vector}, {60'b0, IRQ_KEY});
      @(negedge clk);
      check("t1_gap", {60'b0, interrupt_vector}, {60'b0, IRQ_NONE});
      rd(STAT, "t1_count", 64'h200);

      // back-to-back bytes
      push(8'h1C); push(8'h32); push(8'h21);
      repeat (15) @(negedge clk);

      // overflow: DEPTH+1 bytes without ack, then clear
      ack_ok = 1'b0;
      for (int i = 0; i <= DEPTH; i++) push(8'h40 + 8'(i));
      rd(STAT, "t3_full_ovf", 64'h308);
      @(negedge clk);
      wr(STAT, 64'h100);
      rd(STAT, "t3_ovf_clear", 64'h208);
      @(negedge clk);

      // full FIFO: push and ack at the same edge
      key_valid = 1'b1; key_data = 8'hAA; ack_ok = 1'b1;
      @(negedge clk);
      key_valid = 1'b0; ack_ok = 1'b0;
      rd(STAT, "t4_same_edge", 64'h208);

      // withdraw and restore the request through CTRL
      repeat (2) @(negedge clk);
      check("t5_pend", {60'b0, interrupt_vector}, {60'b0, IRQ_KEY});
      wr(CTRL, 64'h0);
      @(negedge clk);
      check("t5_withdrawn", {60'b0, interrupt_vector}, {60'b0, IRQ_NONE});
      rd(STAT, "t5_count_kept", 64'h008);
      wr(CTRL, 64'h1);
      @(negedge clk);
      check("t5_restored", {60'b0, interrupt_vector}, {60'b0, IRQ_KEY});
      ack_ok = 1'b1;
      repeat (40) @(negedge clk);

      // asynchronous reset mid-request
      ack_ok = 1'b0;
      push(8'h61); push(8'h62); push(8'h63);
      repeat (2) @(negedge clk);
      check("t6_pend", {60'b0, interrupt_vector}, {60'b0, IRQ_KEY});
      #1 reset = 1'b0;
      #1 check("t6_async_vec", {60'b0, interrupt_vector}, {60'b0, IRQ_NONE});
      rd(STAT, "t6_async_status", 64'h200);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("t6_no_request", {60'b0, interrupt_vector}, {60'b0, IRQ_NONE});
      rd(KEY_BASE, "t6_data_empty", 64'h0);
      @(negedge clk);

      // randomized traffic
      ack_ok = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         int r;
         ack_pct   = 50;
         key_valid = ($urandom_range(0, 99) < 35);
         key_data  = 8'($urandom);
         r = $urandom_range(0, 99);
         if (r < 3)
            wr(CTRL, {$urandom, $urandom_range(0, 3) != 0 ? 32'h1 : 32'h0});
         else if (r < 6)
            wr(STAT, {$urandom, $urandom});
         else if (r < 8)
            wr(KEY_BASE, {$urandom, $urandom});
         else
            @(negedge clk);
      end
      key_valid = 1'b0;
      wr(CTRL, 64'h1);
      ack_pct = 100;
      repeat (40) @(negedge clk);
      check("drain_empty", 64'(exp_q.size()), 64'h0);
      rd(STAT, "drain_status", {54'b0, 1'b1, m_ovf, 8'h0});

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
